dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
Parametrised load/store data memory that replaces the single-word, single-cycle data memory in the MIPS datapath. It accepts byte-addressed requests over a valid/ready handshake and supports byte, halfword and word accesses, with sign or zero extension on loads. It has configurable wait states to model slower memory and flags misaligned or out-of-range accesses. It sits between the ALU address output and the register-file write-back mux, and is driven by the multi-cycle control unit.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; byte address space is 4*DEPTH_WORDS.
WAIT_STATES, 0, extra access cycles before the response (0..15).
CNT_W, 4, width of the wait-state counter; must hold WAIT_STATES.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1=store, 0=load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  one-cycle response strobe.
rsp_rdata  out  32  load result; 0 for stores and errors.
rsp_err  out  1  misaligned, out-of-range or illegal-size request.
busy  out  1  state != IDLE.

Behaviour:
- Reset state: reset is asynchronous, active-high; the clock is clk. On reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
- Memory array is not cleared by reset. It is zero-initialised at time 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid at edge E0, capture we, size, signed, addr and wdata into registers. Load counter=WAIT_STATES. Go to ACCESS.
  - ACCESS: req_ready=0. If counter!=0, decrement. If counter==0, at the next edge perform the access, register rsp_rdata/rsp_err, and go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: rsp_valid rises at edge E0+WAIT_STATES+1. req_ready is low for WAIT_STATES+2 cycles per request. Requests presented while req_ready=0 are ignored.
- rsp_rdata and rsp_err hold their values after rsp_valid falls, until the next response.
- Error conditions: half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS; size=11.
  - On error: no memory write, rsp_err=1, rsp_rdata=0, same latency as a normal access.
- Byte lanes are little-endian, lane = addr[1:0].
  - Stores merge into the word: byte writes 1 lane, half writes lanes {addr[1],0} and {addr[1],1}, word writes all 4.
  - Loads extract the addressed lane(s) and sign- or zero-extend to 32 bits. For word loads, req_signed is ignored.
- Commit point: the memory write and read sampling both occur at the edge entering RESP.
  - Reset asserted any time before that edge aborts the request: no write, no response.
  - Reset during RESP clears rsp_valid immediately; the write has already committed.
- Successful store response: rsp_valid=1, rsp_err=0, rsp_rdata=0.

Decomposition:
- Shared package dmem_lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding IDLE/ACCESS/RESP.
- One combinational sub-module, lsu_lane_fmt: inputs size, signed, addr[1:0], old word, wdata. Outputs are the merged store word, the extended load value and the misalign flag.
- The FSM, counter and memory array stay in dmem_lsu.

Test Plan:
1. sw addr 8 data 0x80FF1234, then lw addr 8 -> rsp_rdata=0x80FF1234, rsp_err=0. Each rsp_valid rises exactly 1 edge after accept (WAIT_STATES=0). req_ready is low for 2 cycles.
2. After test 1: lb addr 9 signed -> 0x00000012; lb addr 11 signed -> 0xFFFFFF80; lbu addr 11 -> 0x00000080; lh addr 10 signed -> 0xFFFF80FF; lhu addr 10 -> 0x000080FF.
3. sb addr 8 wdata 0xFFFFFFAB, then sh addr 10 wdata 0x00005566, then lw addr 8 -> 0x556612AB.
4. Errors:
   - lw addr 6 -> rsp_err=1, rsp_rdata=0.
   - sh addr 9 wdata 0x1111 -> rsp_err=1, and a subsequent lw addr 8 is unchanged.
   - lw addr 256 (DEPTH_WORDS=64) -> rsp_err=1.
   - size=11 -> rsp_err=1.
5. WAIT_STATES=3: accept at E0 -> rsp_valid high only in the cycle after E0+4. busy=1 for 5 cycles. A second req_valid held during busy is accepted only once req_ready returns to 1.
6. WAIT_STATES=3:
   - sw addr 4 data 0xDEADBEEF, reset pulsed mid-ACCESS -> outputs return to reset values, no rsp_valid, and a later lw addr 4 -> 0x00000000.
   - Repeat with reset asserted during RESP -> lw addr 4 -> 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the load/store data memory:
//   - access size encodings (byte / half / word, 2'b11 is illegal)
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - small helper that classifies the size field
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

  // Access size as presented on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Request sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Upper bound on the configurable wait-state count.
  localparam int MAX_WAIT_STATES = 15;

  // True when the size field names a real access width.
  function automatic logic size_is_legal(input logic [1:0] size);
    return (size != SZ_ILL);
  endfunction

endpackage

// File: rtl/dmem_lsu_lane_fmt.sv
// -----------------------------------------------------------------------------
// lsu_lane_fmt
// Purely combinational byte-lane formatter for the data memory.
// Little-endian lanes: lane = addr_lo.
//
// Ports:
//   size        in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   load_signed in  1   1 = sign-extend loads, 0 = zero-extend
//   addr_lo     in  2   byte offset inside the word
//   old_word    in  32  current contents of the addressed word
//   wdata       in  32  right-aligned store data
//   store_word  out 32  old_word with the addressed lane(s) replaced
//   load_word   out 32  addressed lane(s) extended to 32 bits
//   misalign    out 1   half on odd address or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module lsu_lane_fmt
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_word,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store merge: only the addressed lane(s) take new data.
  always_comb begin
    store_word = old_word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    store_word = {old_word[31:8], wdata[7:0]};
          2'd1:    store_word = {old_word[31:16], wdata[7:0], old_word[7:0]};
          2'd2:    store_word = {old_word[31:24], wdata[7:0], old_word[15:0]};
          2'd3:    store_word = {wdata[7:0], old_word[23:0]};
          default: store_word = old_word;
        endcase
      end
      SZ_HALF: begin
        // addr_lo[0] is ignored here; a set bit is reported as misaligned.
        if (addr_lo[1]) begin
          store_word = {wdata[15:0], old_word[15:0]};
        end else begin
          store_word = {old_word[31:16], wdata[15:0]};
        end
      end
      SZ_WORD: store_word = wdata;
      default: store_word = old_word;
    endcase
  end

  // Lane extraction for byte and half loads.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo)
      2'd0:    byte_s = old_word[7:0];
      2'd1:    byte_s = old_word[15:8];
      2'd2:    byte_s = old_word[23:16];
      2'd3:    byte_s = old_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = old_word[31:16];
    end else begin
      half_s = old_word[15:0];
    end
  end

  // Load extension; word loads pass straight through.
  always_comb begin
    load_word = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        if (load_signed) begin
          load_word = {{24{byte_s[7]}}, byte_s};
        end else begin
          load_word = {24'h00_0000, byte_s};
        end
      end
      SZ_HALF: begin
        if (load_signed) begin
          load_word = {{16{half_s[15]}}, half_s};
        end else begin
          load_word = {16'h0000, half_s};
        end
      end
      SZ_WORD: load_word = old_word;
      default: load_word = 32'h0000_0000;
    endcase
  end

  // Alignment check per access size.
  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_HALF: misalign = addr_lo[0];
      SZ_WORD: misalign = (addr_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store data memory with a valid/ready request port and a one-cycle
// response strobe. Byte, half and word accesses, sign/zero-extended loads,
// configurable wait states, and error reporting for misaligned, out-of-range
// and illegal-size requests.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (byte space = 4*DEPTH_WORDS)
//   WAIT_STATES  extra ACCESS cycles before the response (0..15)
//   CNT_W        wait-state counter width
//
// Ports:
//   clk, reset              clock / asynchronous active-high reset
//   req_valid, req_ready    request handshake (accepted in IDLE only)
//   req_we, req_size,
//   req_signed, req_addr,
//   req_wdata               request fields, captured on acceptance
//   rsp_valid               one-cycle response strobe
//   rsp_rdata, rsp_err      response data / error, held until next response
//   busy                    high whenever a request is in flight
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  import dmem_lsu_pkg::*;

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Sequencing and captured request.
  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               we_r;
  logic [1:0]         size_r;
  logic               signed_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;

  // Registered outputs.
  logic               req_ready_r;
  logic               rsp_valid_r;
  logic [31:0]        rsp_rdata_r;
  logic               rsp_err_r;
  logic               busy_r;

  // Storage: not touched by reset, starts at zero.
  logic [31:0]        mem_r [0:DEPTH_WORDS-1] = '{default: 32'h0000_0000};

  // Access-path combinational signals.
  logic [IDX_W-1:0]   idx_s;
  logic               in_range_s;
  logic [31:0]        rd_word_s;
  logic [31:0]        store_word_s;
  logic [31:0]        load_word_s;
  logic               misalign_s;
  logic               err_s;
  logic               commit_s;

  assign idx_s      = addr_r[IDX_W+1:2];
  assign in_range_s = (addr_r[31:2] < 30'(DEPTH_WORDS));
  assign err_s      = misalign_s | ~in_range_s | ~size_is_legal(size_r);
  // The access happens on the edge that leaves ACCESS with the counter spent.
  assign commit_s   = (state_r == ACCESS) && (cnt_r == {CNT_W{1'b0}});

  // Read the addressed word; out-of-range addresses never index the array.
  always_comb begin
    if (in_range_s) begin
      rd_word_s = mem_r[idx_s];
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  lsu_lane_fmt u_lane_fmt (
    .size        (size_r),
    .load_signed (signed_r),
    .addr_lo     (addr_r[1:0]),
    .old_word    (rd_word_s),
    .wdata       (wdata_r),
    .store_word  (store_word_s),
    .load_word   (load_word_s),
    .misalign    (misalign_s)
  );

  // Memory write at the commit edge; errored requests leave memory untouched.
  always_ff @(posedge clk) begin
    if (commit_s && we_r && !err_s) begin
      mem_r[idx_s] <= store_word_s;
    end
  end

  // Request FSM, wait-state counter, request capture and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      signed_r    <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (req_valid) begin
            we_r        <= req_we;
            size_r      <= req_size;
            signed_r    <= req_signed;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            cnt_r       <= CNT_W'(WAIT_STATES);
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(32'd1);
          end else begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            // Stores and errors return zero data.
            if (err_s || we_r) begin
              rsp_rdata_r <= 32'h0000_0000;
            end else begin
              rsp_rdata_r <= load_word_s;
            end
            state_r <= RESP;
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          cnt_r       <= {CNT_W{1'b0}};
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;

endmodule
